// File: rtl/vip_dvp_tx_pkg.sv
// Shared types for the DVP frame transmitter: FSM state encoding and pixel width.
package vip_dvp_tx_pkg;

    localparam int unsigned PIX_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StVsync,
        StVback,
        StWaitLine,
        StLine,
        StHblank,
        StVfront
    } tx_state_e;

endpackage

// File: rtl/vip_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count; writes on full are dropped.
module vip_sync_fifo #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic [AW:0]   count
);

    localparam int unsigned Depth = 1 << AW;
    localparam int unsigned CntW  = AW + 1;

    logic [DW-1:0]   mem [Depth];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            empty;
    logic            wr_fire;
    logic            rd_fire;

    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    assign wr_fire = wr_en & ~full;
    assign rd_fire = rd_en & ~empty;
    assign rd_data = mem[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            // Simultaneous write and read leaves the count unchanged.
            unique case ({wr_fire, rd_fire})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/vip_dvp_frame_tx.sv
// Re-times a clken-gated gray stream into DVP frames through a one-line-plus FIFO.
// Optional test-pattern source enabled by defining VIP_DVP_TX_TESTPAT_EN (adds port tp_en).
module vip_dvp_frame_tx
    import vip_dvp_tx_pkg::*;
#(
    parameter int unsigned IMG_HDISP        = 10,
    parameter int unsigned IMG_VDISP        = 8,
    parameter int unsigned H_BLANK          = 4,
    parameter int unsigned V_SYNC           = 2,
    parameter int unsigned V_BACK           = 3,
    parameter int unsigned V_FRONT          = 2,
    parameter logic        CMOS_VSYNC_VALID = 1'b1,
    parameter int unsigned FIFO_AW          = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             per_frame_vsync,
    input  logic             per_frame_href,
    input  logic             per_frame_clken,
    input  logic [PIX_W-1:0] per_img_Gray,
`ifdef VIP_DVP_TX_TESTPAT_EN
    input  logic             tp_en,
`endif
    output logic             cmos_vsync,
    output logic             cmos_href,
    output logic [PIX_W-1:0] cmos_data,
    output logic             tx_busy,
    output logic             ovf_flag
);

    localparam int unsigned CntW = FIFO_AW + 1;

    tx_state_e        state_q, state_d;
    logic [7:0]       phase_q, phase_d;
    logic [7:0]       line_q, line_d;
    logic [7:0]       phase_last;
    logic             phase_end;
    logic             vsync_prev_q;
    logic             vsync_rise;
    logic             line_ready;
    logic             last_line;
    logic             tp_mode;

    logic             fifo_wr;
    logic             fifo_rd;
    logic             fifo_full;
    logic [PIX_W-1:0] fifo_rdata;
    logic [CntW-1:0]  fifo_count;

    logic             vsync_q;
    logic             href_q;
    logic [PIX_W-1:0] data_q;
    logic             busy_q;
    logic             ovf_q;

    assign fifo_wr    = per_frame_href & per_frame_clken;
    assign vsync_rise = per_frame_vsync & ~vsync_prev_q;
    assign last_line  = (line_q == 8'(IMG_VDISP - 1));
    assign line_ready = tp_mode | (fifo_count >= CntW'(IMG_HDISP));

    vip_sync_fifo #(
        .DW(PIX_W),
        .AW(FIFO_AW)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (fifo_wr),
        .wr_data(per_img_Gray),
        .rd_en  (fifo_rd),
        .rd_data(fifo_rdata),
        .full   (fifo_full),
        .count  (fifo_count)
    );

`ifdef VIP_DVP_TX_TESTPAT_EN
    logic tp_q;

    // Pattern mode is latched once per frame so a mid-frame tp_en change has no effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            tp_q <= 1'b0;
        end else if (state_q == StIdle && vsync_rise) begin
            tp_q <= tp_en;
        end
    end

    assign tp_mode = tp_q;
`else
    assign tp_mode = 1'b0;
`endif

    always_comb begin
        phase_last = '0;
        unique case (state_q)
            StVsync:  phase_last = 8'(V_SYNC - 1);
            StVback:  phase_last = 8'(V_BACK - 1);
            StLine:   phase_last = 8'(IMG_HDISP - 1);
            StHblank: phase_last = 8'(H_BLANK - 1);
            StVfront: phase_last = 8'(V_FRONT - 1);
            default:  phase_last = '0;
        endcase
    end

    assign phase_end = (phase_q == phase_last);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q + 8'd1;
        line_d  = line_q;
        fifo_rd = 1'b0;
        unique case (state_q)
            StIdle: begin
                phase_d = '0;
                if (vsync_rise) begin
                    state_d = StVsync;
                    line_d  = '0;
                end
            end
            StVsync: begin
                if (phase_end) begin
                    state_d = StVback;
                    phase_d = '0;
                end
            end
            // A line only starts once a whole line is buffered, so it never underflows.
            StVback: begin
                if (phase_end) begin
                    state_d = line_ready ? StLine : StWaitLine;
                    phase_d = '0;
                end
            end
            StWaitLine: begin
                phase_d = '0;
                if (line_ready) begin
                    state_d = StLine;
                end
            end
            StLine: begin
                fifo_rd = ~tp_mode;
                if (phase_end) begin
                    state_d = StHblank;
                    phase_d = '0;
                end
            end
            StHblank: begin
                if (phase_end) begin
                    phase_d = '0;
                    if (last_line) begin
                        state_d = StVfront;
                    end else begin
                        line_d  = line_q + 8'd1;
                        state_d = line_ready ? StLine : StWaitLine;
                    end
                end
            end
            StVfront: begin
                if (phase_end) begin
                    state_d = StIdle;
                    phase_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
                phase_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            phase_q      <= '0;
            line_q       <= '0;
            vsync_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            line_q       <= line_d;
            vsync_prev_q <= per_frame_vsync;
        end
    end

    // All outputs follow the state by one register stage; the FWFT head is read in LINE.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q <= ~CMOS_VSYNC_VALID;
            href_q  <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            vsync_q <= (state_q == StVsync) ? CMOS_VSYNC_VALID : ~CMOS_VSYNC_VALID;
            href_q  <= (state_q == StLine);
            busy_q  <= (state_q != StIdle);
            if (state_q == StLine) begin
                data_q <= tp_mode ? PIX_W'(phase_q + line_q) : fifo_rdata;
            end else begin
                data_q <= '0;
            end
            if (fifo_wr && fifo_full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign cmos_vsync = vsync_q;
    assign cmos_href  = href_q;
    assign cmos_data  = data_q;
    assign tx_busy    = busy_q;
    assign ovf_flag   = ovf_q;

endmodule

// File: tb/tb_vip_dvp_frame_tx.sv
// Self-checking bench for vip_dvp_frame_tx: frame-level model plus directed scenarios.
module tb_vip_dvp_frame_tx;

    localparam int HD    = 10;
    localparam int VD    = 8;
    localparam int HB    = 4;
    localparam int VS    = 2;
    localparam int VB    = 3;
    localparam int VF    = 2;
    localparam int DEPTH = 32;

    logic       clk;
    logic       rst;
    logic       vsync;
    logic       href;
    logic       clken;
    logic [7:0] gray;
    logic       tp_en;
    logic       cmos_vsync;
    logic       cmos_href;
    logic [7:0] cmos_data;
    logic       tx_busy;
    logic       ovf_flag;

    vip_dvp_frame_tx dut (
        .clk            (clk),
        .rst            (rst),
        .per_frame_vsync(vsync),
        .per_frame_href (href),
        .per_frame_clken(clken),
        .per_img_Gray   (gray),
`ifdef VIP_DVP_TX_TESTPAT_EN
        .tp_en          (tp_en),
`endif
        .cmos_vsync     (cmos_vsync),
        .cmos_href      (cmos_href),
        .cmos_data      (cmos_data),
        .tx_busy        (tx_busy),
        .ovf_flag       (ovf_flag)
    );

    int checks = 0;
    int errors = 0;

    // Model state
    logic [7:0] mq[$];
    logic [7:0] out_log[$];
    logic       m_ovf = 1'b0;
    logic       m_prev = 1'b0;
    logic       rst_seen = 1'b0;
    logic       pending = 1'b0;
    logic       pend_tp = 1'b0;
    logic       fr_active = 1'b0;
    logic       fr_tp = 1'b0;
    int         fr_cyc = 0;
    int         st_lines = 0;
    int         st_vs = 0;
    int         run = 0;
    int         gap = 0;
    int         gap_min = 0;
    int         gap_max = 0;
    int         tail = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Input-side model: frame start detection and FIFO contents.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                m_ovf    = 1'b0;
                m_prev   = 1'b0;
                pending  = 1'b0;
                rst_seen = 1'b1;
            end else begin
                rst_seen = 1'b0;
                if (vsync && !m_prev && !fr_active && !pending) begin
                    pending = 1'b1;
                    pend_tp = tp_en;
                end
                m_prev = vsync;
                if (href && clken) begin
                    if (mq.size() < DEPTH) mq.push_back(gray);
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    // Output-side compare, every cycle at the falling edge.
    initial begin
        logic       href_ok;
        logic       exp_busy;
        logic [7:0] exp_d;
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                chk("rst_href", cmos_href, 0);
                chk("rst_vsync", cmos_vsync, 0);
                chk("rst_busy", tx_busy, 0);
                chk("rst_ovf", ovf_flag, 0);
                chk("rst_data", cmos_data, 0);
                fr_active = 1'b0;
                run = 0;
            end else begin
                if (pending) begin
                    pending   = 1'b0;
                    fr_active = 1'b1;
                    fr_tp     = pend_tp;
                    fr_cyc    = 0;
                    st_lines  = 0;
                    st_vs     = 0;
                    gap       = 0;
                    gap_min   = 9999;
                    gap_max   = 0;
                    tail      = 0;
                    run       = 0;
                    out_log.delete();
                end else if (fr_active) begin
                    fr_cyc++;
                end
                chk("ovf_flag", ovf_flag, m_ovf);
                chk("vsync", cmos_vsync,
                    (fr_active && fr_cyc >= 1 && fr_cyc <= VS) ? 1 : 0);
                if (fr_active && cmos_vsync) st_vs++;
                href_ok = fr_active && fr_cyc > VS + VB && st_lines < VD;
                if (!href_ok) chk("href_window", cmos_href, 0);
                if (cmos_href) begin
                    if (run == 0 && st_lines > 0) begin
                        if (gap < gap_min) gap_min = gap;
                        if (gap > gap_max) gap_max = gap;
                        chk("hblank_min", (gap >= HB) ? 1 : 0, 1);
                    end
                    exp_d = 8'h00;
                    if (fr_tp) begin
                        exp_d = 8'(run + st_lines);
                    end else if (mq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL underflow: href with data %0d but model FIFO empty",
                                 cmos_data);
                    end else begin
                        exp_d = mq.pop_front();
                    end
                    chk("data", cmos_data, exp_d);
                    out_log.push_back(cmos_data);
                    run++;
                end else begin
                    chk("data_idle", cmos_data, 0);
                    if (run > 0) begin
                        chk("href_len", run, HD);
                        st_lines++;
                        run = 0;
                        gap = 1;
                    end else begin
                        gap++;
                    end
                    if (fr_active && st_lines >= VD) tail++;
                end
                exp_busy = fr_active && fr_cyc >= 1 && (st_lines < VD || tail <= HB + VF);
                chk("tx_busy", tx_busy, exp_busy);
                if (fr_active && tail > HB + VF) fr_active = 1'b0;
            end
        end
    end

    task automatic send_pix(input int base, input int n, input int period);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < period; k++) begin
                href  = 1'b1;
                clken = (k == period - 1);
                gray  = 8'(base + i);
                cyc(1);
            end
            if (i % HD == HD - 1 || i == n - 1) begin
                href  = 1'b0;
                clken = 1'b0;
                cyc(HB);
            end
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        vsync = 1'b0;
        href  = 1'b0;
        clken = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((pending || fr_active) && n < 2000) begin
            cyc(1);
            n++;
        end
        checks++;
        if (pending || fr_active) begin
            errors++;
            $display("FAIL %s: frame still active after %0d cycles, required idle", name, n);
        end
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        vsync = 1'b0;
        href  = 1'b0;
        clken = 1'b0;
        gray  = 8'h00;
        tp_en = 1'b0;
        cyc(3);
        chk("reset_vsync", cmos_vsync, 0);
        chk("reset_href", cmos_href, 0);
        chk("reset_data", cmos_data, 0);
        chk("reset_busy", tx_busy, 0);
        chk("reset_ovf", ovf_flag, 0);
        rst = 1'b0;
        cyc(2);

        // 1: contiguous frame, ramp 0..79
        vsync = 1'b1;
        send_pix(0, HD * VD, 1);
        wait_idle("t1_idle");
        chk("t1_vsync_len", st_vs, 2);
        chk("t1_lines", st_lines, 8);
        chk("t1_gap_min", gap_min, 4);
        chk("t1_gap_max", gap_max, 4);
        chk("t1_count", out_log.size(), 80);
        chk("t1_first", out_log[0], 0);
        chk("t1_last", out_log[79], 79);

        // 2: bursty input, clken 1-of-3
        do_reset();
        vsync = 1'b1;
        send_pix(0, HD * VD, 3);
        wait_idle("t2_idle");
        chk("t2_lines", st_lines, 8);
        chk("t2_count", out_log.size(), 80);
        chk("t2_pix45", out_log[45], 45);
        chk("t2_waited", (gap_max > 4) ? 1 : 0, 1);

        // 3: overflow with no frame, then drain what was kept
        do_reset();
        for (int i = 0; i < 40; i++) begin
            href  = 1'b1;
            clken = 1'b1;
            gray  = 8'(i);
            cyc(1);
            if (i == 31) chk("t3_ovf_before", ovf_flag, 0);
            if (i == 32) chk("t3_ovf_after", ovf_flag, 1);
        end
        href  = 1'b0;
        clken = 1'b0;
        vsync = 1'b1;
        n = 0;
        while (!(fr_active && st_lines >= 2) && n < 500) begin
            cyc(1);
            n++;
        end
        chk("t3_two_lines", (st_lines >= 2) ? 1 : 0, 1);
        send_pix(100, 48, 1);
        wait_idle("t3_idle");
        chk("t3_pix31", out_log[31], 31);
        chk("t3_pix32", out_log[32], 100);
        chk("t3_count", out_log.size(), 80);
        chk("t3_ovf_sticky", ovf_flag, 1);

        // 4: second vsync rise mid-frame is ignored
        do_reset();
        vsync = 1'b1;
        send_pix(0, 30, 1);
        vsync = 1'b0;
        cyc(1);
        vsync = 1'b1;
        send_pix(30, 50, 1);
        wait_idle("t4_idle");
        chk("t4_lines", st_lines, 8);
        chk("t4_count", out_log.size(), 80);
        cyc(20);
        chk("t4_no_restart", tx_busy, 0);

        // 5: reset in the middle of a line
        do_reset();
        vsync = 1'b1;
        send_pix(0, 20, 1);
        n = 0;
        while (!cmos_href && n < 50) begin
            cyc(1);
            n++;
        end
        chk("t5_in_line", cmos_href, 1);
        cyc(2);
        rst   = 1'b1;
        vsync = 1'b0;
        cyc(1);
        chk("t5_href", cmos_href, 0);
        chk("t5_vsync", cmos_vsync, 0);
        chk("t5_busy", tx_busy, 0);
        rst = 1'b0;
        cyc(2);
        vsync = 1'b1;
        send_pix(200, HD * VD, 1);
        wait_idle("t5_idle");
        chk("t5_first_new", out_log[0], 200);
        chk("t5_count", out_log.size(), 80);

`ifdef VIP_DVP_TX_TESTPAT_EN
        // 6: test pattern with no input pixels
        do_reset();
        tp_en = 1'b1;
        vsync = 1'b1;
        cyc(2);
        tp_en = 1'b0;
        wait_idle("t6_idle");
        chk("t6_lines", st_lines, 8);
        chk("t6_p0", out_log[0], 0);
        chk("t6_p9", out_log[9], 9);
        chk("t6_p10", out_log[10], 1);
        chk("t6_p79", out_log[79], 16);
`endif

        vsync = 1'b0;
        cyc(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
